// File: rtl/l2_jtag_arbiter.sv
// L2 SRAM arbiter between the JTAG master (m0) and the SoC master (m1).
// Define L2_ARB_PERF_CNT_EN to build the per-port grant counters.
module l2_jtag_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned L2_WORDS     = 16384,
  parameter int unsigned STARVE_LIMIT = 16,
  parameter logic [31:0] ERR_DATA     = 32'hBADACCE5,
  localparam int unsigned AW          = $clog2(L2_WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              prio_mode_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [3:0]        m0_be_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [31:0]       m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [31:0]       m0_rdata_o,
  output logic              m0_err_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [3:0]        m1_be_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [31:0]       m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [31:0]       m1_rdata_o,
  output logic              m1_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [AW-1:0]     mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              perf_clr_i,
  output logic [31:0]       perf_m0_o,
  output logic [31:0]       perf_m1_o
);

  localparam logic [7:0] SL = 8'(STARVE_LIMIT);

  logic              r_rr_ptr;
  logic [7:0]        r_starve;
  logic              r_vld;
  logic              r_port;
  logic              r_err;
  logic              r_we;

  logic [ADDR_W-1:0] w_m0_wa;
  logic [ADDR_W-1:0] w_m1_wa;
  logic              w_ok0;
  logic              w_ok1;
  logic              w_pick1;
  logic              w_g0;
  logic              w_g1;
  logic              w_hit0;
  logic              w_hit1;
  logic [31:0]       w_rdata;
  logic              w_unused;

  assign w_m0_wa = {2'b00, m0_addr_i[ADDR_W-1:2]};
  assign w_m1_wa = {2'b00, m1_addr_i[ADDR_W-1:2]};
  assign w_ok0   = w_m0_wa < ADDR_W'(L2_WORDS);
  assign w_ok1   = w_m1_wa < ADDR_W'(L2_WORDS);

  // Contended winner; grants are gated by reset so the SRAM is idle at once
  assign w_pick1 = prio_mode_i ? (r_starve == SL) : r_rr_ptr;
  assign w_g0    = rst_n & m0_req_i & (~m1_req_i | ~w_pick1);
  assign w_g1    = rst_n & m1_req_i & (~m0_req_i | w_pick1);
  assign w_hit0  = w_g0 & w_ok0;
  assign w_hit1  = w_g1 & w_ok1;

  assign m0_gnt_o = w_g0;
  assign m1_gnt_o = w_g1;

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = 32'h0;
    unique case (1'b1)
      w_hit0: begin
        mem_req_o   = 1'b1;
        mem_we_o    = m0_we_i;
        mem_be_o    = m0_be_i;
        mem_addr_o  = w_m0_wa[AW-1:0];
        mem_wdata_o = m0_wdata_i;
      end
      w_hit1: begin
        mem_req_o   = 1'b1;
        mem_we_o    = m1_we_i;
        mem_be_o    = m1_be_i;
        mem_addr_o  = w_m1_wa[AW-1:0];
        mem_wdata_o = m1_wdata_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= 1'b0;
      r_starve <= 8'h0;
    end else begin
      if (m0_req_i && m1_req_i && !prio_mode_i)
        r_rr_ptr <= ~r_rr_ptr;
      if (!prio_mode_i || !m1_req_i || w_g1)
        r_starve <= 8'h0;
      else if (r_starve != SL)
        r_starve <= r_starve + 8'h1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= 1'b0;
      r_port <= 1'b0;
      r_err  <= 1'b0;
      r_we   <= 1'b0;
    end else begin
      r_vld  <= w_g0 | w_g1;
      r_port <= w_g1;
      r_err  <= w_g1 ? ~w_ok1 : ~w_ok0;
      r_we   <= w_g1 ? m1_we_i : m0_we_i;
    end
  end

  assign w_rdata = r_err ? ERR_DATA :
                   (r_we ? 32'h0 : mem_rdata_i);

  assign m0_rvalid_o = r_vld & ~r_port;
  assign m1_rvalid_o = r_vld & r_port;
  assign m0_err_o    = m0_rvalid_o & r_err;
  assign m1_err_o    = m1_rvalid_o & r_err;
  assign m0_rdata_o  = m0_rvalid_o ? w_rdata : 32'h0;
  assign m1_rdata_o  = m1_rvalid_o ? w_rdata : 32'h0;

`ifdef L2_ARB_PERF_CNT_EN
  logic [31:0] r_perf0;
  logic [31:0] r_perf1;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_perf0 <= 32'h0;
      r_perf1 <= 32'h0;
    end else if (perf_clr_i) begin
      r_perf0 <= 32'h0;
      r_perf1 <= 32'h0;
    end else begin
      if (w_g0 && r_perf0 != 32'hFFFF_FFFF)
        r_perf0 <= r_perf0 + 32'h1;
      if (w_g1 && r_perf1 != 32'hFFFF_FFFF)
        r_perf1 <= r_perf1 + 32'h1;
    end
  end

  assign perf_m0_o = r_perf0;
  assign perf_m1_o = r_perf1;
  assign w_unused  = ^{m0_addr_i[1:0], m1_addr_i[1:0]};
`else
  assign perf_m0_o = 32'h0;
  assign perf_m1_o = 32'h0;
  assign w_unused  = ^{perf_clr_i, m0_addr_i[1:0], m1_addr_i[1:0]};
`endif

endmodule

// File: tb/tb_l2_jtag_arbiter.sv
// Directed bench for l2_jtag_arbiter with a 1-cycle SRAM model.
// Perf expectations follow L2_ARB_PERF_CNT_EN.
module tb_l2_jtag_arbiter;

  localparam int AW = 14;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prio_mode_i = 1'b0;
  logic        m0_req_i = 1'b0, m0_we_i = 1'b0;
  logic [3:0]  m0_be_i = 4'hF;
  logic [31:0] m0_addr_i = '0, m0_wdata_i = '0;
  logic        m1_req_i = 1'b0, m1_we_i = 1'b0;
  logic [3:0]  m1_be_i = 4'hF;
  logic [31:0] m1_addr_i = '0, m1_wdata_i = '0;
  logic        perf_clr_i = 1'b0;
  logic        m0_gnt_o, m0_rvalid_o, m0_err_o;
  logic        m1_gnt_o, m1_rvalid_o, m1_err_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;
  logic [31:0] perf_m0_o, perf_m1_o;

  logic [31:0] mem [0:16383];

  int n_vec = 0;
  int n_err = 0;

  l2_jtag_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i(clk), .rst_n(rst_n), .prio_mode_i(prio_mode_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
    .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
    .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
    .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
    .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
    .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .perf_clr_i(perf_clr_i),
    .perf_m0_o(perf_m0_o), .perf_m1_o(perf_m1_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) mem[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        mem_rdata_i <= mem[mem_addr_o];
      end
    end
  end

  function automatic logic [226:0] all_outs();
    return {m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_err_o,
            m1_err_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o,
            mem_wdata_o, m0_rdata_o, m1_rdata_o, perf_m0_o, perf_m1_o,
            mem_req_o, 31'h0};
  endfunction

  task automatic idle();
    m0_req_i = 1'b0;
    m1_req_i = 1'b0;
    m0_we_i  = 1'b0;
    m1_we_i  = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++;
    if (all_outs() !== '0) begin
      n_err++;
      $display("FAIL reset_outs: got %h want 0", all_outs());
    end
    m0_req_i = 1'b1;
    #1;
    n_vec++;
    if ({m0_gnt_o, mem_req_o} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_req_gated: gnt,mem_req=%b want 00",
               {m0_gnt_o, mem_req_o});
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({m0_rvalid_o, m1_rvalid_o} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_release_rvalid: got %b want 00",
               {m0_rvalid_o, m1_rvalid_o});
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    m0_req_i = 1'b1; m0_we_i = 1'b1; m0_be_i = 4'hF;
    m0_addr_i = 32'h0; m0_wdata_i = 32'hABBAABBA;
    #1;
    n_vec++;
    if ({m0_gnt_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}
        !== {3'b111, 14'h0, 32'hABBAABBA}) begin
      n_err++;
      $display("FAIL wr_grant: gnt=%b req=%b we=%b addr=%h wd=%h",
               m0_gnt_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({m0_rvalid_o, m0_err_o, m0_rdata_o, m1_rvalid_o}
        !== {2'b10, 32'h0, 1'b0}) begin
      n_err++;
      $display("FAIL wr_resp: rv=%b err=%b rd=%h want 1 0 0",
               m0_rvalid_o, m0_err_o, m0_rdata_o);
    end
    @(negedge clk);
    m0_we_i = 1'b0;
    #1;
    n_vec++;
    if ({m0_gnt_o, mem_req_o, mem_we_o} !== 3'b110) begin
      n_err++;
      $display("FAIL rd_grant: gnt,req,we=%b want 110",
               {m0_gnt_o, mem_req_o, mem_we_o});
    end
    @(posedge clk); #1;
    idle();
    n_vec++;
    if ({m0_rvalid_o, m0_err_o, m0_rdata_o, m1_rvalid_o}
        !== {2'b10, 32'hABBAABBA, 1'b0}) begin
      n_err++;
      $display("FAIL rd_resp: rv=%b err=%b rd=%h want 1 0 abbaabba",
               m0_rvalid_o, m0_err_o, m0_rdata_o);
    end
  endtask

  task automatic test_round_robin();
    int c0 = 0, c1 = 0;
    logic e1;
    mem[16] = 32'h1111_0000;
    mem[17] = 32'h2222_0001;
    @(negedge clk);
    prio_mode_i = 1'b0;
    m0_req_i = 1'b1; m0_addr_i = 32'h40;
    m1_req_i = 1'b1; m1_addr_i = 32'h44;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      e1 = (i % 2 == 1);
      c0 += int'(m0_gnt_o);
      c1 += int'(m1_gnt_o);
      n_vec++;
      if ({m0_gnt_o, m1_gnt_o} !== {~e1, e1}) begin
        n_err++;
        $display("FAIL rr_gnt[%0d]: g0g1=%b want %b", i,
                 {m0_gnt_o, m1_gnt_o}, {~e1, e1});
      end
      @(posedge clk); #1;
      n_vec++;
      if (e1 ? ({m1_rvalid_o, m1_rdata_o, m0_rvalid_o}
                !== {1'b1, 32'h2222_0001, 1'b0})
             : ({m0_rvalid_o, m0_rdata_o, m1_rvalid_o}
                !== {1'b1, 32'h1111_0000, 1'b0})) begin
        n_err++;
        $display("FAIL rr_resp[%0d]: rv0=%b rd0=%h rv1=%b rd1=%h", i,
                 m0_rvalid_o, m0_rdata_o, m1_rvalid_o, m1_rdata_o);
      end
    end
    idle();
    n_vec++;
    if (c0 != 4 || c1 != 4) begin
      n_err++;
      $display("FAIL rr_count: m0=%0d m1=%0d want 4 4", c0, c1);
    end
  endtask

  task automatic test_fixed_prio();
    int deny = 0, max_deny = 0;
    logic e1;
    @(negedge clk);
    prio_mode_i = 1'b1;
    m0_req_i = 1'b1; m0_addr_i = 32'h40;
    m1_req_i = 1'b1; m1_addr_i = 32'h44;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      e1 = (i % 5 == 4);
      n_vec++;
      if ({m0_gnt_o, m1_gnt_o} !== {~e1, e1}) begin
        n_err++;
        $display("FAIL fix_gnt[%0d]: g0g1=%b want %b", i,
                 {m0_gnt_o, m1_gnt_o}, {~e1, e1});
      end
      deny = m1_gnt_o ? 0 : deny + 1;
      if (deny > max_deny) max_deny = deny;
      @(posedge clk); #1;
    end
    idle();
    n_vec++;
    if (max_deny > 4) begin
      n_err++;
      $display("FAIL fix_starve: max deny %0d want <=4", max_deny);
    end
    @(negedge clk);
    prio_mode_i = 1'b0;
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    m1_req_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = 32'h0001_0000;
    #1;
    n_vec++;
    if ({m1_gnt_o, mem_req_o} !== 2'b10) begin
      n_err++;
      $display("FAIL oor_grant: gnt,mem_req=%b want 10",
               {m1_gnt_o, mem_req_o});
    end
    @(posedge clk); #1;
    n_vec++;
    if ({m1_rvalid_o, m1_err_o, m1_rdata_o, m0_rvalid_o}
        !== {2'b11, 32'hBADACCE5, 1'b0}) begin
      n_err++;
      $display("FAIL oor_resp: rv=%b err=%b rd=%h want 1 1 badacce5",
               m1_rvalid_o, m1_err_o, m1_rdata_o);
    end
    @(negedge clk);
    m1_we_i = 1'b1; m1_wdata_i = 32'h5555_5555;
    #1;
    n_vec++;
    if ({m1_gnt_o, mem_req_o} !== 2'b10) begin
      n_err++;
      $display("FAIL oor_wr_drop: gnt,mem_req=%b want 10",
               {m1_gnt_o, mem_req_o});
    end
    @(posedge clk); #1;
    n_vec++;
    if ({m1_rvalid_o, m1_err_o} !== 2'b11) begin
      n_err++;
      $display("FAIL oor_wr_resp: rv,err=%b want 11",
               {m1_rvalid_o, m1_err_o});
    end
    mem[16383] = 32'h0BAD_F00D;
    @(negedge clk);
    m1_we_i = 1'b0; m1_addr_i = 32'h0000_FFFC;
    #1;
    n_vec++;
    if ({m1_gnt_o, mem_req_o, mem_addr_o} !== {2'b11, 14'h3FFF}) begin
      n_err++;
      $display("FAIL last_word_grant: gnt=%b req=%b addr=%h want 1 1 3fff",
               m1_gnt_o, mem_req_o, mem_addr_o);
    end
    @(posedge clk); #1;
    idle();
    n_vec++;
    if ({m1_rvalid_o, m1_err_o, m1_rdata_o} !== {2'b10, 32'h0BAD_F00D}) begin
      n_err++;
      $display("FAIL last_word_resp: rv=%b err=%b rd=%h want 1 0 0badf00d",
               m1_rvalid_o, m1_err_o, m1_rdata_o);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    prio_mode_i = 1'b0;
    m0_req_i = 1'b1; m0_addr_i = 32'h40;
    m1_req_i = 1'b1; m1_addr_i = 32'h44;
    #1;
    n_vec++;
    if ({m0_gnt_o, m1_gnt_o} !== 2'b10) begin
      n_err++;
      $display("FAIL rst_pre_gnt: g0g1=%b want 10", {m0_gnt_o, m1_gnt_o});
    end
    @(posedge clk); #1;
    m1_req_i = 1'b0;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (all_outs() !== '0) begin
      n_err++;
      $display("FAIL rst_mid_outs: got %h want 0", all_outs());
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({m0_rvalid_o, m1_rvalid_o} !== 2'b00) begin
        n_err++;
        $display("FAIL rst_no_rvalid[%0d]: got %b want 00", i,
                 {m0_rvalid_o, m1_rvalid_o});
      end
    end
    @(negedge clk);
    m0_req_i = 1'b1;
    m1_req_i = 1'b1;
    #1;
    n_vec++;
    if ({m0_gnt_o, m1_gnt_o} !== 2'b10) begin
      n_err++;
      $display("FAIL rst_rr_ptr: g0g1=%b want 10", {m0_gnt_o, m1_gnt_o});
    end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_perf();
    logic [31:0] e0, e1;
`ifdef L2_ARB_PERF_CNT_EN
    e0 = 32'd10;
    e1 = 32'd3;
`else
    e0 = 32'd0;
    e1 = 32'd0;
`endif
    @(negedge clk);
    perf_clr_i = 1'b1;
    @(posedge clk); #1;
    perf_clr_i = 1'b0;
    n_vec++;
    if ({perf_m0_o, perf_m1_o} !== 64'h0) begin
      n_err++;
      $display("FAIL perf_clr: m0=%0d m1=%0d want 0 0", perf_m0_o, perf_m1_o);
    end
    m0_addr_i = 32'h0;
    m1_addr_i = 32'h0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      m0_req_i = (i < 10);
      m1_req_i = (i >= 10);
      @(posedge clk); #1;
    end
    idle();
    n_vec++;
    if ({perf_m0_o, perf_m1_o} !== {e0, e1}) begin
      n_err++;
      $display("FAIL perf_count: m0=%0d m1=%0d want %0d %0d",
               perf_m0_o, perf_m1_o, e0, e1);
    end
    @(negedge clk);
    m0_req_i = 1'b1;
    perf_clr_i = 1'b1;
    @(posedge clk); #1;
    idle();
    perf_clr_i = 1'b0;
    n_vec++;
    if ({perf_m0_o, perf_m1_o} !== 64'h0) begin
      n_err++;
      $display("FAIL perf_clr_wins: m0=%0d m1=%0d want 0 0",
               perf_m0_o, perf_m1_o);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_fixed_prio();
    test_out_of_range();
    test_reset_mid();
    test_perf();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
